// File: rtl/pipeline_stage_regs.sv
// Pipeline register chain F/D -> D/E -> E/M -> M/W with per-instruction control fields,
// plus retire/stall/flush event counters for performance monitoring.

package pipeline_stage_regs_pkg;
    typedef enum logic [1:0] {
        RESULT_SRC_ALU = 2'd0,
        RESULT_SRC_MEM = 2'd1,
        RESULT_SRC_PC4 = 2'd2
    } result_src_t;
endpackage

module pipeline_stage_regs
    import pipeline_stage_regs_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned COUNT_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        f_instr,
    input  logic [XLEN-1:0]    f_pc,
    input  logic               f_valid,
    input  logic               d_stall,
    input  logic               d_flush,
    input  logic               e_flush,
    input  logic               d_reg_write,
    input  result_src_t        d_result_src,
    output logic [31:0]        d_instr,
    output logic [XLEN-1:0]    d_pc,
    output logic [4:0]         d_rs1,
    output logic [4:0]         d_rs2,
    output logic [4:0]         e_rs1,
    output logic [4:0]         e_rs2,
    output logic [4:0]         e_rd,
    output logic [XLEN-1:0]    e_pc,
    output logic               e_reg_write,
    output result_src_t        e_result_src,
    output logic [4:0]         m_rd,
    output logic [4:0]         w_rd,
    output logic               m_reg_write,
    output logic               w_reg_write,
    output result_src_t        m_result_src,
    output result_src_t        w_result_src,
    output logic               w_valid,
    output logic [COUNT_W-1:0] instret_count,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    logic d_valid;
    logic e_valid;
    logic m_valid;

    logic [31:0]      fd_instr_d;
    logic [XLEN-1:0]  fd_pc_d;
    logic             fd_valid_d;

    logic [4:0]       de_rs1_d;
    logic [4:0]       de_rs2_d;
    logic [4:0]       de_rd_d;
    logic [XLEN-1:0]  de_pc_d;
    logic             de_reg_write_d;
    result_src_t      de_result_src_d;
    logic             de_valid_d;

    logic [COUNT_W-1:0] instret_d;
    logic [COUNT_W-1:0] stall_d;
    logic [COUNT_W-1:0] flush_d;

    // Decoder-facing register indices are slices of the registered instruction.
    assign d_rs1 = d_instr[19:15];
    assign d_rs2 = d_instr[24:20];

    // F/D next state: flush beats stall, stall holds, otherwise take the fetched word.
    always_comb begin
        fd_instr_d = d_instr;
        fd_pc_d    = d_pc;
        fd_valid_d = d_valid;
        if (d_flush) begin
            fd_instr_d = NOP_INSTR;
            fd_pc_d    = '0;
            fd_valid_d = 1'b0;
        end else if (!d_stall) begin
            fd_instr_d = f_instr;
            fd_pc_d    = f_pc;
            fd_valid_d = f_valid;
        end
    end

    // F/D register.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_instr <= NOP_INSTR;
            d_pc    <= '0;
            d_valid <= 1'b0;
        end else begin
            d_instr <= fd_instr_d;
            d_pc    <= fd_pc_d;
            d_valid <= fd_valid_d;
        end
    end

    // D/E next state: no stall input; a flush inserts a bubble with ALU result source so
    // it can never match a load-use compare.
    always_comb begin
        de_rs1_d        = d_rs1;
        de_rs2_d        = d_rs2;
        de_rd_d         = d_instr[11:7];
        de_pc_d         = d_pc;
        de_reg_write_d  = d_reg_write;
        de_result_src_d = d_result_src;
        de_valid_d      = d_valid;
        if (e_flush) begin
            de_rs1_d        = '0;
            de_rs2_d        = '0;
            de_rd_d         = '0;
            de_pc_d         = '0;
            de_reg_write_d  = 1'b0;
            de_result_src_d = RESULT_SRC_ALU;
            de_valid_d      = 1'b0;
        end
    end

    // D/E register.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs1        <= '0;
            e_rs2        <= '0;
            e_rd         <= '0;
            e_pc         <= '0;
            e_reg_write  <= 1'b0;
            e_result_src <= RESULT_SRC_ALU;
            e_valid      <= 1'b0;
        end else begin
            e_rs1        <= de_rs1_d;
            e_rs2        <= de_rs2_d;
            e_rd         <= de_rd_d;
            e_pc         <= de_pc_d;
            e_reg_write  <= de_reg_write_d;
            e_result_src <= de_result_src_d;
            e_valid      <= de_valid_d;
        end
    end

    // E/M and M/W registers always advance. rd=x0 keeps its reg_write; x0 is masked downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_rd         <= '0;
            m_reg_write  <= 1'b0;
            m_result_src <= RESULT_SRC_ALU;
            m_valid      <= 1'b0;
            w_rd         <= '0;
            w_reg_write  <= 1'b0;
            w_result_src <= RESULT_SRC_ALU;
            w_valid      <= 1'b0;
        end else begin
            m_rd         <= e_rd;
            m_reg_write  <= e_reg_write;
            m_result_src <= e_result_src;
            m_valid      <= e_valid;
            w_rd         <= m_rd;
            w_reg_write  <= m_reg_write;
            w_result_src <= m_result_src;
            w_valid      <= m_valid;
        end
    end

    // Event counter next state; all wrap modulo 2^COUNT_W.
    always_comb begin
        instret_d = instret_count;
        stall_d   = stall_count;
        flush_d   = flush_count;
        if (w_valid) begin
            instret_d = instret_count + COUNT_W'(1);
        end
        if (d_stall && !d_flush) begin
            stall_d = stall_count + COUNT_W'(1);
        end
        if (d_flush) begin
            flush_d = flush_count + COUNT_W'(1);
        end
    end

    // Event counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_count <= '0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            instret_count <= instret_d;
            stall_count   <= stall_d;
            flush_count   <= flush_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Bench for pipeline_stage_regs: scoreboard of expected retirements checked at M/W,
// plus per-scenario checks of stage contents and event counters.

module tb_pipeline_stage_regs;
    import pipeline_stage_regs_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic [1:0] src;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic        f_valid;
    logic        d_stall;
    logic        d_flush;
    logic        e_flush;
    logic        d_reg_write;
    result_src_t d_result_src;

    logic [31:0] d_instr, d_pc, e_pc;
    logic [4:0]  d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic        e_reg_write, m_reg_write, w_reg_write, w_valid;
    result_src_t e_result_src, m_result_src, w_result_src;
    logic [31:0] instret_count, stall_count, flush_count;

    logic [31:0] n_d_instr, n_d_pc, n_e_pc;
    logic [4:0]  n_d_rs1, n_d_rs2, n_e_rs1, n_e_rs2, n_e_rd, n_m_rd, n_w_rd;
    logic        n_e_reg_write, n_m_reg_write, n_w_reg_write, n_w_valid;
    result_src_t n_e_result_src, n_m_result_src, n_w_result_src;
    logic [3:0]  n_instret, n_stall, n_flush;

    int   total = 0;
    int   bad   = 0;
    int   exp_instret = 0;
    int   exp_stall   = 0;
    int   exp_flush   = 0;
    exp_t sb[$];
    exp_t mon_e;

    pipeline_stage_regs #(.XLEN(32), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .f_instr(f_instr), .f_pc(f_pc), .f_valid(f_valid),
        .d_stall(d_stall), .d_flush(d_flush), .e_flush(e_flush),
        .d_reg_write(d_reg_write), .d_result_src(d_result_src),
        .d_instr(d_instr), .d_pc(d_pc), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_pc(e_pc),
        .e_reg_write(e_reg_write), .e_result_src(e_result_src),
        .m_rd(m_rd), .w_rd(w_rd), .m_reg_write(m_reg_write), .w_reg_write(w_reg_write),
        .m_result_src(m_result_src), .w_result_src(w_result_src), .w_valid(w_valid),
        .instret_count(instret_count), .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy to exercise wrap-around.
    pipeline_stage_regs #(.XLEN(32), .COUNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .f_instr(f_instr), .f_pc(f_pc), .f_valid(f_valid),
        .d_stall(d_stall), .d_flush(d_flush), .e_flush(e_flush),
        .d_reg_write(d_reg_write), .d_result_src(d_result_src),
        .d_instr(n_d_instr), .d_pc(n_d_pc), .d_rs1(n_d_rs1), .d_rs2(n_d_rs2),
        .e_rs1(n_e_rs1), .e_rs2(n_e_rs2), .e_rd(n_e_rd), .e_pc(n_e_pc),
        .e_reg_write(n_e_reg_write), .e_result_src(n_e_result_src),
        .m_rd(n_m_rd), .w_rd(n_w_rd), .m_reg_write(n_m_reg_write),
        .w_reg_write(n_w_reg_write), .m_result_src(n_m_result_src),
        .w_result_src(n_w_result_src), .w_valid(n_w_valid),
        .instret_count(n_instret), .stall_count(n_stall), .flush_count(n_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal decoder standing in for the real one.
    always_comb begin
        d_reg_write  = 1'b0;
        d_result_src = RESULT_SRC_ALU;
        if (d_instr[6:0] == 7'h13 || d_instr[6:0] == 7'h33) d_reg_write = 1'b1;
        if (d_instr[6:0] == 7'h03) begin
            d_reg_write  = 1'b1;
            d_result_src = RESULT_SRC_MEM;
        end
    end

    // Retirement monitor: every w_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (w_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got w_rd=%0d, required no retirement", w_rd);
            end else begin
                mon_e = sb.pop_front();
                if ({w_rd, w_reg_write, w_result_src} !== {mon_e.rd, mon_e.rw, mon_e.src}) begin
                    bad++;
                    $display("FAIL retire_fields: got rd=%0d rw=%0b src=%0d, required rd=%0d rw=%0b src=%0d",
                             w_rd, w_reg_write, w_result_src, mon_e.rd, mon_e.rw, mon_e.src);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_instr = NOP;
        f_pc    = 32'h0;
        f_valid = 1'b0;
        d_stall = 1'b0;
        d_flush = 1'b0;
        e_flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({d_instr, d_pc} !== {NOP, 32'h0}) begin
            bad++;
            $display("FAIL reset_fd: got instr=%h pc=%h, required %h/0", d_instr, d_pc, NOP);
        end
        total++;
        if ({e_rd, m_rd, w_rd, e_reg_write, m_reg_write, w_reg_write, w_valid} !== 20'h0) begin
            bad++;
            $display("FAIL reset_stages: got e_rd=%0d m_rd=%0d w_rd=%0d we=%0b%0b%0b wv=%0b, required 0",
                     e_rd, m_rd, w_rd, e_reg_write, m_reg_write, w_reg_write, w_valid);
        end
        total++;
        if ({instret_count, stall_count, flush_count, n_instret, n_stall, n_flush} !== 108'h0) begin
            bad++;
            $display("FAIL reset_counters: got %0d/%0d/%0d narrow %0d/%0d/%0d, required 0",
                     instret_count, stall_count, flush_count, n_instret, n_stall, n_flush);
        end
        reset = 1'b0;
    endtask

    task automatic check_counters(input string name);
        total++;
        if ({instret_count, stall_count, flush_count} !==
            {32'(exp_instret), 32'(exp_stall), 32'(exp_flush)}) begin
            bad++;
            $display("FAIL %s_counters: got instret=%0d stall=%0d flush=%0d, required %0d/%0d/%0d",
                     name, instret_count, stall_count, flush_count,
                     exp_instret, exp_stall, exp_flush);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending retirements, required 0", name, sb.size());
        end
    endtask

    task automatic test_basic();
        f_instr = 32'h0050_0293; f_pc = 32'h100; f_valid = 1'b1;
        sb.push_back(exp_t'({5'd5, 1'b1, 2'd0}));
        tick();
        total++;
        if ({d_rs1, d_instr, d_pc} !== {5'd0, 32'h0050_0293, 32'h100}) begin
            bad++;
            $display("FAIL basic_d: got rs1=%0d instr=%h pc=%h, required 0/00500293/100",
                     d_rs1, d_instr, d_pc);
        end
        idle_inputs();
        tick();
        total++;
        if ({e_rd, e_pc, e_reg_write} !== {5'd5, 32'h100, 1'b1}) begin
            bad++;
            $display("FAIL basic_e: got rd=%0d pc=%h we=%0b, required 5/100/1", e_rd, e_pc, e_reg_write);
        end
        tick();
        total++;
        if (m_rd !== 5'd5) begin
            bad++;
            $display("FAIL basic_m: got m_rd=%0d, required 5", m_rd);
        end
        tick();
        total++;
        if ({w_rd, w_valid, instret_count} !== {5'd5, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL basic_w: got rd=%0d valid=%0b instret=%0d, required 5/1/0",
                     w_rd, w_valid, instret_count);
        end
        tick();
        exp_instret = 1;
        check_counters("basic");
    endtask

    task automatic test_load_use();
        f_instr = 32'h0000_A303; f_pc = 32'h200; f_valid = 1'b1;       // lw x6,0(x1)
        sb.push_back(exp_t'({5'd6, 1'b1, 2'd1}));
        tick();
        f_instr = 32'h0063_03B3; f_pc = 32'h204;                       // add x7,x6,x6
        sb.push_back(exp_t'({5'd7, 1'b1, 2'd0}));
        tick();
        total++;
        if ({d_rs1, d_rs2, e_rd, e_result_src} !== {5'd6, 5'd6, 5'd6, RESULT_SRC_MEM}) begin
            bad++;
            $display("FAIL lu_setup: got rs1=%0d rs2=%0d e_rd=%0d src=%0d, required 6/6/6/1",
                     d_rs1, d_rs2, e_rd, e_result_src);
        end
        f_instr = 32'h0080_0413; f_pc = 32'h208;                       // addi x8,x0,8
        sb.push_back(exp_t'({5'd8, 1'b1, 2'd0}));
        d_stall = 1'b1; e_flush = 1'b1;
        tick();
        exp_stall = 1;
        total++;
        if ({d_instr, d_pc, e_rd, e_result_src, e_reg_write, m_rd, stall_count} !==
            {32'h0063_03B3, 32'h204, 5'd0, RESULT_SRC_ALU, 1'b0, 5'd6, 32'd1}) begin
            bad++;
            $display("FAIL lu_stall: got d=%h pc=%h e_rd=%0d src=%0d we=%0b m_rd=%0d stalls=%0d, required 006303b3/204/0/0/0/6/1",
                     d_instr, d_pc, e_rd, e_result_src, e_reg_write, m_rd, stall_count);
        end
        d_stall = 1'b0; e_flush = 1'b0;
        tick();
        total++;
        if ({d_instr, e_rd} !== {32'h0080_0413, 5'd7}) begin
            bad++;
            $display("FAIL lu_resume: got d=%h e_rd=%0d, required 00800413/7", d_instr, e_rd);
        end
        idle_inputs();
        repeat (6) tick();
        exp_instret = 4;
        check_counters("load_use");
    endtask

    task automatic test_flush();
        f_instr = 32'h0090_0493; f_pc = 32'h300; f_valid = 1'b1;       // killed in D
        tick();
        f_instr = 32'h00A0_0513; f_pc = 32'h304;                       // killed in F
        d_flush = 1'b1; e_flush = 1'b1;
        tick();
        exp_flush = 1;
        total++;
        if ({d_instr, d_pc, e_rd, e_pc, e_reg_write, flush_count, stall_count} !==
            {NOP, 32'h0, 5'd0, 32'h0, 1'b0, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL flush_bubbles: got d=%h dpc=%h e_rd=%0d epc=%h we=%0b flush=%0d stall=%0d, required 13/0/0/0/0/1/1",
                     d_instr, d_pc, e_rd, e_pc, e_reg_write, flush_count, stall_count);
        end
        d_flush = 1'b0; e_flush = 1'b0;
        f_instr = 32'h00B0_0593; f_pc = 32'h308;
        sb.push_back(exp_t'({5'd11, 1'b1, 2'd0}));
        tick();
        idle_inputs();
        repeat (6) tick();
        exp_instret = 5;
        check_counters("flush");
    endtask

    task automatic test_stall_flush();
        f_instr = 32'h00C0_0613; f_pc = 32'h400; f_valid = 1'b1;
        sb.push_back(exp_t'({5'd12, 1'b1, 2'd0}));
        tick();
        f_instr = 32'h00D0_0693; f_pc = 32'h404;
        d_stall = 1'b1; d_flush = 1'b1;
        tick();
        exp_flush = 2;
        total++;
        if ({d_instr, e_rd, stall_count, flush_count} !== {NOP, 5'd12, 32'd1, 32'd2}) begin
            bad++;
            $display("FAIL stall_flush: got d=%h e_rd=%0d stall=%0d flush=%0d, required 13/12/1/2",
                     d_instr, e_rd, stall_count, flush_count);
        end
        idle_inputs();
        repeat (6) tick();
        exp_instret = 6;
        check_counters("stall_flush");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_instret = 0; exp_stall = 0; exp_flush = 0;
        for (int i = 0; i < 17; i++) begin
            ins = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};                 // addi x<i>,x0,i (i=0 is x0)
            f_instr = ins; f_pc = 32'h500 + 32'(4 * i); f_valid = 1'b1;
            sb.push_back(exp_t'({5'(i), 1'b1, 2'd0}));
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        exp_instret = 17;
        check_counters("b2b");
        total++;
        if (n_instret !== 4'd1) begin
            bad++;
            $display("FAIL b2b_wrap: got narrow instret=%0d, required 1", n_instret);
        end
        d_stall = 1'b1; e_flush = 1'b1;
        tick();
        tick();
        total++;
        if ({stall_count, n_stall} !== {32'd2, 4'd2}) begin
            bad++;
            $display("FAIL b2b_stalls: got %0d narrow %0d, required 2/2", stall_count, n_stall);
        end
        d_stall = 1'b0; e_flush = 1'b0;
        f_instr = 32'h0010_0093; f_pc = 32'h600; f_valid = 1'b1;
        tick();
        f_instr = 32'h0020_0113; f_pc = 32'h604;
        tick();
        reset = 1'b1; d_stall = 1'b1; d_flush = 1'b1;
        tick();
        sb.delete();
        total++;
        if ({instret_count, stall_count, flush_count, n_instret, n_stall, n_flush} !== 108'h0) begin
            bad++;
            $display("FAIL midrun_reset_counters: got %0d/%0d/%0d narrow %0d/%0d/%0d, required 0",
                     instret_count, stall_count, flush_count, n_instret, n_stall, n_flush);
        end
        total++;
        if ({d_instr, e_rd, m_rd, w_rd, w_valid} !== {NOP, 5'd0, 5'd0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset_stages: got d=%h e_rd=%0d m_rd=%0d w_rd=%0d wv=%0b, required 13/0/0/0/0",
                     d_instr, e_rd, m_rd, w_rd, w_valid);
        end
        reset = 1'b0;
        idle_inputs();
        repeat (5) tick();
        exp_instret = 0; exp_stall = 0; exp_flush = 0;
        check_counters("after_reset");
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_load_use();
        test_flush();
        test_stall_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
